// File: rtl/note_frag_sequencer_pkg.sv
// Shared definitions for the note fragment sequencer: FSM state encoding,
// the REST note code, default geometry and a saturating counter helper.
// Optional feature macro used by the top level: FRAG_PAD_EN.

package note_frag_sequencer_pkg;

    localparam int NOTE_W_DEF         = 8;
    localparam int NOTES_PER_FRAG_DEF = 150;
    localparam int NOTE_REST          = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL_A,
        ST_FILL_B,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_FINISH
    } state_t;

    // Pair counter stops at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/note_frag_sequencer_frag_shift_reg.sv
// One fragment register: writes a single note slot, clears to REST,
// or loads a whole fragment (used to slide B into A).
// Priority: clear, then load, then slot write.

module frag_shift_reg
    import note_frag_sequencer_pkg::*;
#(
    parameter int  NOTE_W         = NOTE_W_DEF,
    parameter int  NOTES_PER_FRAG = NOTES_PER_FRAG_DEF,
    localparam int FRAG_W         = NOTE_W * NOTES_PER_FRAG,
    localparam int IDX_W          = $clog2(NOTES_PER_FRAG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [FRAG_W-1:0] load_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [NOTE_W-1:0] wr_data,
    output logic [FRAG_W-1:0] frag
);

    // Fragment storage with clear / whole-load / single-slot write.
    // NOTE: this wide register is reset on purpose: the fragment is a visible
    // output that must read all-zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frag <= '0;
        end else if (clear) begin
            frag <= {NOTES_PER_FRAG{NOTE_W'(NOTE_REST)}};
        end else if (load) begin
            frag <= load_data;
        end else if (wr_en) begin
            frag[int'(wr_idx) * NOTE_W +: NOTE_W] <= wr_data;
        end
    end

endmodule

// File: rtl/note_frag_sequencer.sv
// Packs a serial note stream into fixed-length fragments and hands
// consecutive overlapping pairs (A = fragment n, B = fragment n+1) to the
// Markov learning stage, holding both stable until mm_done.
// Optional feature: define FRAG_PAD_EN to issue a final partial B fragment
// (its unwritten slots are REST); without it the partial fragment is dropped.

module note_frag_sequencer
    import note_frag_sequencer_pkg::*;
#(
    parameter int NOTE_W         = NOTE_W_DEF,
    parameter int NOTES_PER_FRAG = NOTES_PER_FRAG_DEF,
    parameter int FRAG_W         = NOTE_W * NOTES_PER_FRAG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              song_start,
    input  logic              note_valid,
    input  logic [NOTE_W-1:0] note_data,
    input  logic              note_last,
    output logic              note_ready,
    output logic [FRAG_W-1:0] frag_a,
    output logic [FRAG_W-1:0] frag_b,
    output logic              mm_start,
    input  logic              mm_done,
    output logic [15:0]       pair_count,
    output logic              busy,
    output logic              song_done
);

    localparam int IDX_W = $clog2(NOTES_PER_FRAG);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cnt;
    logic               end_seen;
    logic               last_slot;

    logic               clr_all;
    logic               wr_a;
    logic               wr_b;
    logic               slide;
    logic               cnt_inc;
    logic               cnt_clr;
    logic               pair_inc;
    logic               end_set;

    assign last_slot = (cnt == IDX_W'(NOTES_PER_FRAG - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake outputs and datapath strobes.
    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        note_ready = 1'b0;
        mm_start   = 1'b0;
        song_done  = 1'b0;
        busy       = (state != ST_IDLE);
        clr_all    = 1'b0;
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        slide      = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        pair_inc   = 1'b0;
        end_set    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (song_start) begin
                    clr_all   = 1'b1;
                    state_nxt = ST_FILL_A;
                end
            end

            ST_FILL_A: begin
                note_ready = 1'b1;
                if (note_valid) begin
                    wr_a = 1'b1;
                    if (note_last) begin
                        // A song shorter than two fragments yields no pair.
                        state_nxt = ST_FINISH;
                    end else if (last_slot) begin
                        cnt_clr   = 1'b1;
                        state_nxt = ST_FILL_B;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            ST_FILL_B: begin
                note_ready = 1'b1;
                if (note_valid) begin
                    wr_b = 1'b1;
                    if (last_slot) begin
                        cnt_clr   = 1'b1;
                        end_set   = note_last;
                        state_nxt = ST_ISSUE;
                    end else if (note_last) begin
                        cnt_clr = 1'b1;
`ifdef FRAG_PAD_EN
                        // Remaining slots are already REST from the B clear.
                        end_set   = 1'b1;
                        state_nxt = ST_ISSUE;
`else
                        // Partial B is discarded.
                        state_nxt = ST_FINISH;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                mm_start  = 1'b1;
                pair_inc  = 1'b1;
                state_nxt = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                if (mm_done) begin
                    if (end_seen) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        slide     = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = ST_FILL_B;
                    end
                end
            end

            ST_FINISH: begin
                song_done = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Slot counter, end-of-song flag and saturating pair counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            end_seen   <= 1'b0;
            pair_count <= '0;
        end else begin
            if (clr_all || cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + IDX_W'(1);
            end

            if (clr_all) begin
                end_seen <= 1'b0;
            end else if (end_set) begin
                end_seen <= 1'b1;
            end

            if (clr_all) begin
                pair_count <= '0;
            end else if (pair_inc) begin
                pair_count <= sat_inc16(pair_count);
            end
        end
    end

    frag_shift_reg #(
        .NOTE_W         (NOTE_W),
        .NOTES_PER_FRAG (NOTES_PER_FRAG)
    ) u_frag_a (
        .clk       (clk),
        .reset     (reset),
        .clear     (clr_all),
        .load      (slide),
        .load_data (frag_b),
        .wr_en     (wr_a),
        .wr_idx    (cnt),
        .wr_data   (note_data),
        .frag      (frag_a)
    );

    frag_shift_reg #(
        .NOTE_W         (NOTE_W),
        .NOTES_PER_FRAG (NOTES_PER_FRAG)
    ) u_frag_b (
        .clk       (clk),
        .reset     (reset),
        .clear     (clr_all || slide),
        .load      (1'b0),
        .load_data ('0),
        .wr_en     (wr_b),
        .wr_idx    (cnt),
        .wr_data   (note_data),
        .frag      (frag_b)
    );

endmodule

// File: tb/tb_note_frag_sequencer.sv
// Self-checking bench for note_frag_sequencer. Songs are chopped into
// fragments by a reference model; the expected pairs go into a scoreboard
// queue that a separate responder/monitor process pops on every mm_start.
// Honours FRAG_PAD_EN the same way the design does.

module tb_note_frag_sequencer;

    localparam int NOTE_W = 8;
    localparam int N      = 150;
    localparam int FW     = NOTE_W * N;

`ifdef FRAG_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    typedef logic [FW-1:0] frag_t;
    typedef struct {
        frag_t a;
        frag_t b;
        int    idx;
    } pair_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              song_start;
    logic              note_valid;
    logic [NOTE_W-1:0] note_data;
    logic              note_last;
    logic              note_ready;
    frag_t             frag_a;
    frag_t             frag_b;
    logic              mm_start;
    logic              mm_done;
    logic [15:0]       pair_count;
    logic              busy;
    logic              song_done;

    int    checks = 0;
    int    errors = 0;
    pair_t exp_q[$];
    int    resp_delay = -1;

    always #5 clk = ~clk;

    note_frag_sequencer #(
        .NOTE_W         (NOTE_W),
        .NOTES_PER_FRAG (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .song_start (song_start),
        .note_valid (note_valid),
        .note_data  (note_data),
        .note_last  (note_last),
        .note_ready (note_ready),
        .frag_a     (frag_a),
        .frag_b     (frag_b),
        .mm_start   (mm_start),
        .mm_done    (mm_done),
        .pair_count (pair_count),
        .busy       (busy),
        .song_done  (song_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_frag(input string name, input frag_t act, input frag_t exp);
        int bad;
        checks++;
        if (act !== exp) begin
            errors++;
            bad = 0;
            for (int k = 0; k < N; k++) begin
                if (act[k*NOTE_W +: NOTE_W] !== exp[k*NOTE_W +: NOTE_W]) begin
                    bad = k;
                    break;
                end
            end
            $display("FAIL %s: slot %0d got 0x%02h expected 0x%02h", name, bad,
                     act[bad*NOTE_W +: NOTE_W], exp[bad*NOTE_W +: NOTE_W]);
        end
    endtask

    // Fragment = `count` consecutive notes starting at `base`, REST elsewhere.
    function automatic frag_t build_frag(input logic [7:0] notes[$], input int base, input int count);
        frag_t f = '0;
        for (int k = 0; k < count; k++) f[k*NOTE_W +: NOTE_W] = notes[base + k];
        return f;
    endfunction

    // Reference: split the song into N-note chunks; every complete chunk after
    // the first pairs with its predecessor; a trailing partial chunk pairs
    // only when padding is enabled.
    task automatic model_song(input logic [7:0] notes[$], output int npairs);
        int    full = notes.size() / N;
        int    rem  = notes.size() % N;
        frag_t frags[$];
        pair_t p;
        for (int f = 0; f < full; f++) frags.push_back(build_frag(notes, f * N, N));
        if (rem > 0) frags.push_back(build_frag(notes, full * N, rem));
        npairs = 0;
        for (int b = 1; b < full; b++) begin
            p.a = frags[b-1]; p.b = frags[b]; p.idx = npairs;
            exp_q.push_back(p);
            npairs++;
        end
        if (PAD && rem > 0 && full >= 1) begin
            p.a = frags[full-1]; p.b = frags[full]; p.idx = npairs;
            exp_q.push_back(p);
            npairs++;
        end
    endtask

    function automatic void make_song(input int len, input bit rnd, output logic [7:0] notes[$]);
        notes = {};
        for (int i = 0; i < len; i++) notes.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i));
    endfunction

    // Learning-stage stand-in: checks each issued pair against the scoreboard,
    // answers mm_done after a delay, verifies the pair is held meanwhile, and
    // throws stray mm_done pulses while notes are being accepted.
    initial begin : responder
        pair_t e;
        bit    pending = 1'b0;
        bit    have_exp = 1'b0;
        int    cnt = 0;
        logic  next_done;
        mm_done = 1'b0;
        forever begin
            @(negedge clk);
            next_done = 1'b0;
            if (pending && mm_done) begin
                if (have_exp) begin
                    check_frag("hold_frag_a", frag_a, e.a);
                    check_frag("hold_frag_b", frag_b, e.b);
                    check("hold_note_ready", 32'(note_ready), 32'd0);
                    check("hold_pair_count", 32'(pair_count), 32'(e.idx + 1));
                end
                pending = 1'b0;
            end else begin
                if (!pending && mm_start) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mm_start: got pulse expected none (pair_count 0x%0h)", pair_count);
                        have_exp = 1'b0;
                    end else begin
                        e = exp_q.pop_front();
                        have_exp = 1'b1;
                        check_frag("pair_frag_a", frag_a, e.a);
                        check_frag("pair_frag_b", frag_b, e.b);
                        check("issue_pair_count", 32'(pair_count), 32'(e.idx));
                    end
                    pending = 1'b1;
                    cnt = (resp_delay >= 0) ? resp_delay : int'($urandom_range(0, 20));
                end
                if (pending) begin
                    if (cnt == 0) next_done = 1'b1;
                    else cnt--;
                end else if (note_ready && $urandom_range(0, 15) == 0) begin
                    next_done = 1'b1;
                end
            end
            @(posedge clk);
            #1 mm_done = next_done;
        end
    end

    task automatic start_song();
        @(posedge clk);
        #1 song_start = 1'b1;
        @(posedge clk);
        #1 song_start = 1'b0;
    endtask

    // Feeds notes with random gaps; while stalled, keeps note_valid high and
    // throws stray song_start pulses that must be ignored.
    task automatic feed_notes(input logic [7:0] notes[$], input bit mark_last, output bit ok);
        bit rdy;
        int tries;
        ok = 1'b1;
        for (int i = 0; i < notes.size(); i++) begin
            if ($urandom_range(0, 4) == 0) begin
                note_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            note_valid = 1'b1;
            note_data  = notes[i];
            note_last  = mark_last && (i == notes.size() - 1);
            tries = 0;
            rdy   = 1'b0;
            while (!rdy && tries < 100) begin
                @(negedge clk);
                rdy = note_ready;
                @(posedge clk);
                #1;
                if (!rdy) begin
                    tries++;
                    song_start = ($urandom_range(0, 3) == 0);
                end
            end
            song_start = 1'b0;
            if (!rdy) begin
                check("note_accept_timeout", 32'(i), 32'(-1));
                ok = 1'b0;
                break;
            end
        end
        note_valid = 1'b0;
        note_last  = 1'b0;
    endtask

    task automatic run_song(input string tag, input int len, input bit rnd);
        logic [7:0] notes[$];
        int         np;
        bit         ok;
        bit         seen;
        make_song(len, rnd, notes);
        model_song(notes, np);
        start_song();
        feed_notes(notes, 1'b1, ok);
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (song_done) seen = 1'b1;
        end
        check({tag, "_song_done"}, 32'(seen), 32'd1);
        if (seen) check({tag, "_pair_count"}, 32'(pair_count), 32'(np));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_idle_after"}, {30'd0, busy, song_done}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {16'd0, pair_count}, 32'd0);
        check({tag, "_flags"}, {28'd0, note_ready, mm_start, busy, song_done}, 32'd0);
        check_frag({tag, "_frag_a"}, frag_a, '0);
        check_frag({tag, "_frag_b"}, frag_b, '0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] notes[$];
        bit         ok;
        reset      = 1'b0;
        song_start = 1'b0;
        note_valid = 1'b0;
        note_data  = '0;
        note_last  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(negedge clk) reset = 1'b1;

        // Abort mid-FILL_B: 160 notes, no last.
        make_song(160, 1'b0, notes);
        start_song();
        feed_notes(notes, 1'b0, ok);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk) reset = 1'b1;

        run_song("s300", 300, 1'b0);
        resp_delay = 20;
        run_song("s450", 450, 1'b0);
        resp_delay = -1;
        run_song("s100", 100, 1'b0);
        run_song("s200", 200, 1'b0);
        run_song("s150", 150, 1'b0);
        run_song("s151", 151, 1'b0);

        for (int s = 0; s < 6; s++) begin
            run_song($sformatf("rnd%0d", s), int'($urandom_range(1, 650)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
